// File: rtl/move_input_conditioner_if.sv
// rtl/move_input_conditioner_if.sv - button/move-code bundle between buttons, conditioner and game FSM
// Purpose : groups the raw button inputs and the conditioned move outputs.
// Signals : btn[N_BTN-1:0] raw buttons (1=pressed)
//           x[2:0]         move code, 000 = no move
//           x_valid        pulse on first cycle of each move
//           err            pulse when a multi-button press is rejected
//           busy           conditioner not idle
// Modports: master = conditioner side, slave = button/consumer side.
interface move_input_conditioner_if #(
   parameter int N_BTN = 7
);
   logic [N_BTN-1:0] btn;
   logic [2:0]       x;
   logic             x_valid;
   logic             err;
   logic             busy;

   modport master (input btn, output x, x_valid, err, busy);
   modport slave  (output btn, input x, x_valid, err, busy);
endinterface

// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - push-button synchronizer/debouncer producing game move codes
// Purpose : synchronizes and debounces N_BTN raw buttons, rejects multi-press,
//           emits one move code per press and requires release before the next.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous reset, active low
//           bus  - move_input_conditioner_if.master (btn in; x, x_valid, err, busy out)
module move_input_conditioner #(
   parameter int N_BTN       = 7,
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 1
) (
   input logic                     clk,
   input logic                     rst,
   move_input_conditioner_if.master bus
);
   localparam int CMAX = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam logic [CW-1:0]    DEB_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_ONE   = 1;
   localparam logic [N_BTN-1:0] BTN_ONE   = 1;

   generate
      if (N_BTN < 1 || N_BTN > 7) begin : g_bad_nbtn
         $error("move_input_conditioner: N_BTN must be in 1..7");
      end
      if (DEB_CYCLES < 2) begin : g_bad_deb
         $error("move_input_conditioner: DEB_CYCLES must be >= 2");
      end
      if (HOLD_CYCLES < 1) begin : g_bad_hold
         $error("move_input_conditioner: HOLD_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;

   state_t           state;
   logic [N_BTN-1:0] s1, bs, snap;
   logic [CW-1:0]    cnt;
   logic [2:0]       code;
   logic             x_valid_q, err_q, busy_q;

   logic [2:0]       code_c;
   logic             snap_onehot;

   // snap is never zero while debouncing, so the power-of-two test alone
   // identifies a single pressed button.
   assign snap_onehot = (snap & (snap - BTN_ONE)) == '0;

   always_comb begin
      code_c = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (snap[i]) code_c = 3'(i + 1);
      end
   end

   // code doubles as the x register: it only holds a value while in EMIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1        <= '0;
         bs        <= '0;
         snap      <= '0;
         cnt       <= '0;
         code      <= '0;
         x_valid_q <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         state     <= IDLE;
      end else begin
         s1        <= bus.btn;
         bs        <= s1;
         x_valid_q <= 1'b0;
         err_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (bs != '0) begin
                  snap   <= bs;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (bs == '0) begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else if (bs != snap) begin
                  snap <= bs;
                  cnt  <= '0;
               end else if (cnt != DEB_LAST) begin
                  cnt <= cnt + CNT_ONE;
               end else if (snap_onehot) begin
                  code      <= code_c;
                  x_valid_q <= 1'b1;
                  cnt       <= '0;
                  state     <= EMIT;
               end else begin
                  err_q <= 1'b1;
                  cnt   <= '0;
                  state <= RELEASE;
               end
            end
            EMIT: begin
               if (cnt == HOLD_LAST) begin
                  code  <= '0;
                  cnt   <= '0;
                  state <= RELEASE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            RELEASE: begin
               if (bs != '0) begin
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               code   <= '0;
               cnt    <= '0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.x       = code;
   assign bus.x_valid = x_valid_q;
   assign bus.err     = err_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_move_input_conditioner.sv
// tb/tb_move_input_conditioner.sv - self-checking bench for move_input_conditioner
module tb_move_input_conditioner;
   logic clk;
   logic rst;

   move_input_conditioner_if #(.N_BTN(7)) bus ();

   move_input_conditioner #(
      .N_BTN(7), .DEB_CYCLES(4), .HOLD_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int         n_valid;
   int         n_err;
   int         n_xcyc;
   int         last_code;
   logic [7:0] seen;

   typedef struct {
      logic [6:0] btn;
      int         press;
      int         code;
      int         valid;
      int         err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic clr();
      n_valid   = 0;
      n_err     = 0;
      n_xcyc    = 0;
      last_code = 0;
      seen      = '0;
   endtask

   // Apply b for n clock edges, observing outputs 1 time unit after each edge.
   task automatic step(input logic [6:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         bus.btn = b;
         @(posedge clk);
         #1;
         if (bus.x_valid) begin
            n_valid++;
            last_code = int'(bus.x);
         end
         if (bus.err) n_err++;
         if (bus.x != 3'b000) begin
            n_xcyc++;
            seen[bus.x] = 1'b1;
         end
      end
   endtask

   initial begin
      int found;

      vecs[0] = '{7'h01, 10, 1, 1, 0};
      vecs[1] = '{7'h08, 10, 4, 1, 0};
      vecs[2] = '{7'h40, 10, 7, 1, 0};
      vecs[3] = '{7'h05, 10, 0, 0, 1};
      vecs[4] = '{7'h03, 10, 0, 0, 1};
      vecs[5] = '{7'h02,  3, 0, 0, 0};
      vecs[6] = '{7'h7f, 10, 0, 0, 1};

      // 1: reset state, then latency from reset release with button held
      rst     = 1'b0;
      bus.btn = 7'h04;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", int'(bus.x), 0);
      chk("rst_x_valid", int'(bus.x_valid), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_busy", int'(bus.busy), 0);
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("lat_x_e%0d", k), int'(bus.x), (k == 6 || k == 7) ? 3 : 0);
         chk($sformatf("lat_valid_e%0d", k), int'(bus.x_valid), (k == 6) ? 1 : 0);
         chk($sformatf("lat_busy_e%0d", k), int'(bus.busy), (k >= 2) ? 1 : 0);
      end
      clr();
      step(7'h00, 12);
      chk("lat_idle_busy", int'(bus.busy), 0);

      // table of single presses / rejected presses / short presses
      for (int v = 0; v < 7; v++) begin
         clr();
         step(vecs[v].btn, vecs[v].press);
         step(7'h00, 12);
         chk($sformatf("vec%0d_valid", v), n_valid, vecs[v].valid);
         chk($sformatf("vec%0d_code", v), last_code, vecs[v].code);
         chk($sformatf("vec%0d_err", v), n_err, vecs[v].err);
         chk($sformatf("vec%0d_xcycles", v), n_xcyc, 2 * vecs[v].valid);
         chk($sformatf("vec%0d_busy", v), int'(bus.busy), 0);
      end

      // 2: bounce then stable press
      clr();
      for (int r = 0; r < 4; r++) begin
         step(7'h02, 2);
         step(7'h00, 3);
      end
      chk("bounce_valid", n_valid, 0);
      chk("bounce_xcycles", n_xcyc, 0);
      step(7'h02, 10);
      step(7'h00, 12);
      chk("bounce_final_valid", n_valid, 1);
      chk("bounce_final_code", last_code, 2);

      // 3: long hold, one emission, busy until stable release
      clr();
      step(7'h10, 50);
      chk("hold_valid", n_valid, 1);
      chk("hold_code", last_code, 5);
      chk("hold_busy", int'(bus.busy), 1);
      bus.btn = 7'h00;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold_rel_busy_e%0d", k), int'(bus.busy), (k < 5) ? 1 : 0);
      end

      // 4: multi-press rejected, then single press accepted
      clr();
      step(7'h05, 10);
      step(7'h00, 12);
      chk("multi_err", n_err, 1);
      chk("multi_xcycles", n_xcyc, 0);
      clr();
      step(7'h01, 10);
      step(7'h00, 12);
      chk("multi_after_code", last_code, 1);
      chk("multi_after_valid", n_valid, 1);

      // 5: change during debounce restarts on the new button
      clr();
      step(7'h01, 2);
      step(7'h40, 10);
      step(7'h00, 12);
      chk("change_valid", n_valid, 1);
      chk("change_code", last_code, 7);
      chk("change_no_code1", int'(seen[1]), 0);

      // 6: asynchronous reset while emitting code 6
      found = 0;
      bus.btn = 7'h20;
      for (int k = 0; k < 30 && found == 0; k++) begin
         @(posedge clk);
         #1;
         if (bus.x == 3'b110) found = 1;
      end
      chk("async_emit_seen", found, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_x", int'(bus.x), 0);
      chk("async_busy", int'(bus.busy), 0);
      chk("async_valid", int'(bus.x_valid), 0);
      bus.btn = 7'h00;
      @(posedge clk);
      #1;
      rst = 1'b1;
      clr();
      step(7'h00, 6);
      chk("post_reset_busy", int'(bus.busy), 0);
      chk("post_reset_xcycles", n_xcyc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
